array_stream_loader: RTL and testbench
======================================

ARRAY_STREAM_LOADER -- requirements
Module: array_stream_loader

Interface
REQ-001 SHALL have parameter ELEMENTS, default 16, number of array elements per frame (legal range 2..1024).
REQ-002 SHALL have parameter WIDTH, default 32, bits per element.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to begin a new frame.
REQ-006 SHALL have port in_valid  input  1  upstream element valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts element this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream element.
REQ-009 SHALL have port index  output  $clog2(ELEMENTS)  write index to downstream array.
REQ-010 SHALL have port element  output  WIDTH  write data to downstream array.
REQ-011 SHALL have port enable  output  1  write strobe to downstream array.
REQ-012 SHALL have port clear  output  1  zero-all strobe to downstream array.
REQ-013 SHALL have port count  output  $clog2(ELEMENTS+1)  elements written in current/last frame.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  frame complete, array contents stable.
REQ-016 SHALL have port done_ack  input  1  consumer acknowledges done.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, LOAD, FLUSH, DONE.
REQ-018 IDLE: start=1 -> CLEAR; count cleared to 0 on that edge.
REQ-019 CLEAR: clear=1 for exactly one cycle; unconditionally -> LOAD.
REQ-020 LOAD: in_ready=1; in_ready=0 in all other states.
REQ-021 Beat accepted when in_valid&in_ready; next cycle enable=1, index=count before increment, element=in_data (one-cycle registered latency); enable=0 otherwise.
REQ-022 count increments by 1 per accepted beat, never exceeds ELEMENTS.
REQ-023 Acceptance of beat making count==ELEMENTS -> FLUSH; FLUSH lasts one cycle (carries final enable) -> DONE.
REQ-024 DONE: done=1 held until done_ack=1, then -> IDLE; done=0 in all other states.
REQ-025 start SHALL be ignored outside IDLE; done_ack SHALL be ignored outside DONE.
REQ-026 start and done_ack together in DONE: DONE -> IDLE only; start not latched.
REQ-027 in_valid low in LOAD: stall indefinitely, no writes, no timeout.
REQ-028 index, element SHALL hold last values when enable=0.

Reset
REQ-029 reset_n=0 at a rising edge SHALL force IDLE, count=0, index=0, element=0, enable=0, clear=0, done=0, in_ready=0, busy=0 the following cycle.
REQ-030 Reset mid-frame SHALL abort the frame without issuing clear; next frame begins only after new start.

Configuration
REQ-031 Macro ARRAY_STREAM_LOADER_TLAST_EN SHALL add port in_last  input  1  marks final element of a short frame.
REQ-032 With macro: accepted beat with in_last=1 -> FLUSH regardless of count; unwritten elements remain zero from CLEAR; count reports elements written.
REQ-033 Without macro: no in_last port; frame ends only at count==ELEMENTS.

Verification
REQ-034 ELEMENTS=4, WIDTH=8: start, four back-to-back beats 0x11,0x22,0x33,0x44 -> clear one cycle, enable with index 0..3, done two cycles after last accept, count=4.
REQ-035 in_valid toggling every other cycle in LOAD -> writes only on accepted beats, indices contiguous, no enable gaps misaligned with accepts.
REQ-036 done held 5 cycles then done_ack with start=1 -> IDLE, no new frame, in_ready stays 0.
REQ-037 reset_n=0 after 2 of 4 beats -> all outputs zero next cycle, no clear, later start re-runs full frame from index 0.
REQ-038 With ARRAY_STREAM_LOADER_TLAST_EN, ELEMENTS=4: beats 0xAA, 0xBB(in_last=1) -> count=2, done, indices 2..3 never written.

Source files
------------

// File: rtl/array_stream_loader.sv
// array_stream_loader: streams ELEMENTS beats into a downstream array after a clear strobe.
// Optional feature: define ARRAY_STREAM_LOADER_TLAST_EN to add in_last for short frames.
module array_stream_loader #(
    parameter int ELEMENTS = 16,
    parameter int WIDTH = 32,
    localparam int IW = $clog2(ELEMENTS),
    localparam int CW = $clog2(ELEMENTS + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef ARRAY_STREAM_LOADER_TLAST_EN
    input  logic             in_last,
`endif
    output logic [IW-1:0]    index,
    output logic [WIDTH-1:0] element,
    output logic             enable,
    output logic             clear,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    input  logic             done_ack
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FLUSH, DONE} state_t;
    state_t state, state_next;
    logic accept, last_beat;
    assign in_ready = state == LOAD;
    assign clear = state == CLEAR;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign accept = in_ready && in_valid;
`ifdef ARRAY_STREAM_LOADER_TLAST_EN
    assign last_beat = count == CW'(ELEMENTS - 1) || in_last;
`else
    assign last_beat = count == CW'(ELEMENTS - 1);
`endif
    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else state <= state_next;
    end
    // next-state: clear and flush are single-cycle, done waits for the consumer
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? CLEAR : IDLE;
            CLEAR:   state_next = LOAD;
            LOAD:    state_next = accept && last_beat ? FLUSH : LOAD;
            FLUSH:   state_next = DONE;
            DONE:    state_next = done_ack ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end
    // write port registered one cycle behind the accepted beat; index/element hold otherwise
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            index <= '0;
            element <= '0;
            enable <= 1'b0;
        end else begin
            enable <= accept;
            if (accept) begin
                index <= count[IW-1:0];
                element <= in_data;
                count <= count + CW'(1);
            end else if (state == IDLE && start) begin
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_array_stream_loader.sv
// tb_array_stream_loader: randomized and directed checks against a frame-level reference model.
module tb_array_stream_loader;
    localparam int E = 4;
    localparam int W = 8;
`ifdef ARRAY_STREAM_LOADER_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n, start, in_valid, in_ready, enable, clear, busy, done, done_ack, in_last;
    logic [W-1:0] in_data, element;
    logic [1:0] index;
    logic [2:0] count;
    int n_cmp = 0;
    int n_err = 0;
    // model: phase 0 idle, 1 clear, 2 load, 3 flush, 4 done
    int m_phase = 0;
    int m_cnt = 0;
    int m_idx = 0;
    int m_elem = 0;
    bit m_en = 1'b0;
    logic [W-1:0] m_mem [E];
    logic [W-1:0] d_mem [E];

    always #5 clk = ~clk;

    array_stream_loader #(.ELEMENTS(E), .WIDTH(W)) dut (
        .clock(clk),
        .reset_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
`ifdef ARRAY_STREAM_LOADER_TLAST_EN
        .in_last(in_last),
`endif
        .index(index),
        .element(element),
        .enable(enable),
        .clear(clear),
        .count(count),
        .busy(busy),
        .done(done),
        .done_ack(done_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance model by one clock using the inputs presented this cycle
    task automatic model_edge(input bit r, input bit s, input bit v, input bit ack, input bit lst, input logic [W-1:0] d);
        bit acc;
        if (!r) begin
            m_phase = 0; m_cnt = 0; m_idx = 0; m_elem = 0; m_en = 1'b0;
            return;
        end
        acc = m_phase == 2 && v;
        m_en = acc;
        if (acc) begin
            m_idx = m_cnt;
            m_elem = d;
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == E || (TL && lst)) m_phase = 3;
        end else if (m_phase == 0 && s) begin
            m_phase = 1;
            m_cnt = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else if (m_phase == 3) begin
            m_phase = 4;
        end else if (m_phase == 4 && ack) begin
            m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        if (clear) foreach (d_mem[i]) d_mem[i] = '0;
        if (enable) d_mem[index] = element;
        check("in_ready", in_ready, m_phase == 2);
        check("clear", clear, m_phase == 1);
        check("busy", busy, m_phase != 0);
        check("done", done, m_phase == 4);
        check("enable", enable, m_en);
        check("index", index, m_idx);
        check("element", element, m_elem);
        check("count", count, m_cnt);
        if (m_phase == 4) foreach (m_mem[i]) check($sformatf("array[%0d]", i), d_mem[i], m_mem[i]);
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit ack, input bit lst, input logic [W-1:0] d);
        rst_n = r; start = s; in_valid = v; done_ack = ack; in_last = lst; in_data = d;
        model_edge(r, s, v, ack, lst, d);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [W-1:0] beats [4];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        foreach (m_mem[i]) begin m_mem[i] = '0; d_mem[i] = '0; end
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; done_ack = 1'b0; in_last = 1'b0; in_data = '0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 8'hff);
        step(1, 0, 0, 0, 0, 0);
        // back-to-back full frame
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        foreach (beats[i]) step(1, 0, 1, 0, 0, beats[i]);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // valid toggling every other cycle
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, i % 2 == 0, 0, 0, 8'(8'h50 + i));
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        // done_ack together with start: back to idle only
        step(1, 1, 1, 1, 0, 8'h77);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 8'h66);
        // reset after two beats, then full rerun
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'ha1);
        step(1, 0, 1, 0, 0, 8'ha2);
        step(0, 0, 1, 0, 0, 8'ha3);
        step(1, 0, 1, 0, 0, 8'ha4);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 8'(8'hc0 + i));
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
`ifdef ARRAY_STREAM_LOADER_TLAST_EN
        // short frame ended by in_last
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'haa);
        step(1, 0, 1, 0, 1, 8'hbb);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
`endif
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, W'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
